// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Imported by the clear sequencer and the register file top.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NUM_READ   = 2;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: sweeps the register file to zero, one entry per cycle,
// and reports ready once the sweep has finished.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int address_width = ADDR_WIDTH,
    parameter int reg_depth     = REG_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     ready,
    output logic                     clear_we,
    output logic [address_width-1:0] clear_idx
);

    localparam logic [address_width-1:0] last_idx =
        address_width'(reg_depth - 1);

    state_t                   state;
    logic [address_width-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    // hold at the last index; re-entry reloads zero
                    if (count == last_idx) begin
                        state <= READY;
                    end else begin
                        count <= count + address_width'(1);
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        count <= '0;
                    end
                end
            endcase
        end
    end

    assign ready     = (state == READY);
    assign clear_we  = (state == CLEAR);
    assign clear_idx = count;

endmodule

// File: rtl/reg_file_mp.sv
// Register file with two write ports, num_read combinational read ports,
// optional write-to-read forwarding and a sequenced clear.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int address_width = ADDR_WIDTH,
    parameter int reg_depth     = 2 ** address_width,
    parameter int num_read      = NUM_READ,
    parameter int bypass        = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [1:0]                        write_enable,
    input  logic [2*address_width-1:0]        address_d,
    input  logic [2*data_width-1:0]           data_dval,
    input  logic [num_read*address_width-1:0] address_s,
    output logic [num_read*data_width-1:0]    data_sval,
    input  logic                              clear_req,
    output logic                              ready,
    output logic                              write_conflict
);

    logic [data_width-1:0]         regs [reg_depth];
    logic                          clear_we;
    logic [address_width-1:0]      clear_idx;
    logic                          accept;
    logic                          collide;
    logic [1:0][address_width-1:0] wa;
    logic [1:0][data_width-1:0]    wd;
    logic [1:0]                    wr;

    reg_file_clear_seq #(
        .address_width(address_width),
        .reg_depth    (reg_depth)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .clear_req(clear_req),
        .ready    (ready),
        .clear_we (clear_we),
        .clear_idx(clear_idx)
    );

    // a clear request in the same cycle swallows any writes
    assign accept = ready && !clear_req && reset;

    for (genvar k = 0; k < 2; k++) begin : g_wp
        assign wa[k] = address_d[k*address_width +: address_width];
        assign wd[k] = data_dval[k*data_width +: data_width];
        assign wr[k] = accept && write_enable[k] && (wa[k] != '0)
                       && (int'(wa[k]) < reg_depth);
    end

    assign collide = wr[0] && wr[1] && (wa[0] == wa[1]);

    always_ff @(posedge clock) begin
        if (clear_we) begin
            regs[clear_idx] <= '0;
        end else begin
            if (wr[0]) regs[wa[0]] <= wd[0];
            if (wr[1]) regs[wa[1]] <= wd[1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            write_conflict <= 1'b0;
        end else begin
            write_conflict <= collide;
        end
    end

    for (genvar j = 0; j < num_read; j++) begin : g_rp
        logic [address_width-1:0] ra;
        logic [data_width-1:0]    rd;

        assign ra = address_s[j*address_width +: address_width];

        // port 1 is checked last so it wins a same-address collision
        always_comb begin
            rd = '0;
            if (ready && (ra != '0) && (int'(ra) < reg_depth)) begin
                rd = regs[ra];
                if (bypass != 0) begin
                    if (wr[0] && (wa[0] == ra)) rd = wd[0];
                    if (wr[1] && (wa[1] == ra)) rd = wd[1];
                end
            end
        end

        assign data_sval[j*data_width +: data_width] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a forwarding and a non-forwarding instance
// share stimulus; expectations go through a scoreboard queue.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    write_enable = '0;
    logic [2*AW-1:0] address_d = '0;
    logic [2*DW-1:0] data_dval = '0;
    logic [2*AW-1:0] address_s = '0;
    logic          clear_req = 1'b0;
    logic [2*DW-1:0] sval, sval_nb;
    logic          ready, ready_nb, wc, wc_nb;

    int total = 0;
    int bad   = 0;
    int n;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    reg_file_mp #(.bypass(1)) dut (
        .clock(clock), .reset(reset), .write_enable(write_enable),
        .address_d(address_d), .data_dval(data_dval),
        .address_s(address_s), .data_sval(sval),
        .clear_req(clear_req), .ready(ready), .write_conflict(wc)
    );

    reg_file_mp #(.bypass(0)) dut_nb (
        .clock(clock), .reset(reset), .write_enable(write_enable),
        .address_d(address_d), .data_dval(data_dval),
        .address_s(address_s), .data_sval(sval_nb),
        .clear_req(clear_req), .ready(ready_nb), .write_conflict(wc_nb)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input string tag, input int a0, input int a1,
                      input logic [31:0] e0, input logic [31:0] e1);
        address_s = {AW'(a1), AW'(a0)};
        push({tag, "_s0"}, e0);
        push({tag, "_s1"}, e1);
        #1;
        pop_check(sval[31:0]);
        pop_check(sval[63:32]);
    endtask

    task automatic wr(input logic [1:0] en, input int a0, input int a1,
                      input logic [31:0] d0, input logic [31:0] d1);
        write_enable = en;
        address_d    = {AW'(a1), AW'(a0)};
        data_dval    = {d1, d0};
    endtask

    initial begin
        tick();
        tick();
        @(negedge clock);
        push("rst_ready", 0);
        push("rst_wc", 0);
        push("rst_ready_nb", 0);
        pop_check(32'(ready));
        pop_check(32'(wc));
        pop_check(32'(ready_nb));

        // release reset; writes during the sweep must be ignored
        reset = 1'b1;
        wr(2'b11, 4, 6, 32'hbeef, 32'hdead);
        n = 0;
        while (!ready && n < 100) begin
            rd("sweep0", n % 32, 31 - (n % 32), 0, 0);
            tick();
            n++;
        end
        wr(2'b00, 0, 0, 0, 0);
        push("ready_latency", 32);
        pop_check(32'(n));
        push("ready_nb", 1);
        pop_check(32'(ready_nb));
        rd("ign_clr_wr", 4, 6, 0, 0);

        // basic write then read; address 0 stays zero
        wr(2'b01, 5, 0, 32'hA5, 0);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        rd("r5", 5, 0, 32'hA5, 0);
        push("r5_nb", 32'hA5);
        pop_check(sval_nb[31:0]);
        wr(2'b01, 0, 0, 32'hFF, 0);
        rd("r0_fwd", 0, 0, 0, 0);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        rd("r0", 0, 5, 0, 32'hA5);

        // same-cycle forwarding vs old contents
        wr(2'b10, 0, 7, 0, 32'h77);
        rd("byp", 5, 7, 32'hA5, 32'h77);
        push("byp_nb", 0);
        pop_check(sval_nb[63:32]);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        rd("r7", 7, 7, 32'h77, 32'h77);
        push("r7_nb", 32'h77);
        pop_check(sval_nb[63:32]);

        // collision: port 1 wins, conflict flag for one cycle
        wr(2'b11, 9, 9, 32'h11, 32'h22);
        rd("coll_byp", 9, 9, 32'h22, 32'h22);
        push("coll_nb", 0);
        pop_check(sval_nb[31:0]);
        push("wc_pre", 0);
        pop_check(32'(wc));
        tick();
        wr(2'b00, 0, 0, 0, 0);
        push("wc_hit", 1);
        pop_check(32'(wc));
        rd("r9", 9, 9, 32'h22, 32'h22);
        push("r9_nb", 32'h22);
        pop_check(sval_nb[31:0]);
        tick();
        push("wc_drop", 0);
        pop_check(32'(wc));

        // distinct addresses on both ports: no conflict
        wr(2'b11, 10, 11, 32'hAA, 32'hBB);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        push("wc_distinct", 0);
        pop_check(32'(wc));
        rd("r10_11", 10, 11, 32'hAA, 32'hBB);

        // fill, then clear with a simultaneous write
        for (int i = 1; i < 32; i++) begin
            wr(2'b01, i, 0, 32'(i), 0);
            tick();
        end
        wr(2'b00, 0, 0, 0, 0);
        rd("fill_a", 1, 31, 1, 31);
        rd("fill_b", 3, 16, 3, 16);
        clear_req = 1'b1;
        wr(2'b01, 3, 0, 32'h333, 0);
        rd("clr_same", 3, 30, 3, 30);
        tick();
        clear_req = 1'b0;
        wr(2'b00, 0, 0, 0, 0);
        n = 0;
        while (!ready && n < 100) begin
            rd("sweep1", n % 32, 3, 0, 0);
            tick();
            n++;
        end
        push("clear_len", 32);
        pop_check(32'(n));
        for (int i = 0; i < 32; i++) begin
            rd("after_clr", i, (i + 7) % 32, 0, 0);
        end

        // reset mid-sweep restarts; clear_req mid-sweep is ignored
        wr(2'b01, 12, 0, 32'hC, 0);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        rd("r12", 12, 0, 32'hC, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        push("mid_sweep_ready", 0);
        pop_check(32'(ready));
        reset = 1'b0;
        tick();
        push("rst2_ready", 0);
        push("rst2_wc", 0);
        pop_check(32'(ready));
        pop_check(32'(wc));
        reset = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            clear_req = (n == 15);
            tick();
            n++;
        end
        clear_req = 1'b0;
        push("restart_len", 32);
        pop_check(32'(n));
        rd("r12_clr", 12, 9, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter data_width, default 32, bits per register.
REQ-002 SHALL provide parameter address_width, default 5, bits per register address.
REQ-003 SHALL provide parameter reg_depth, default 2**address_width, number of registers.
REQ-004 SHALL provide parameter num_read, default 2, number of read ports (legal range 1..8).
REQ-005 SHALL provide parameter bypass, default 1; when 1, a same-cycle write is forwarded to the read ports; when 0, it is not.
REQ-006 SHALL have port clock, input, 1 bit, single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous, active-low reset.
REQ-008 SHALL have port write_enable, input, 2 bits, per-write-port enable; bit k belongs to write port k.
REQ-009 SHALL have port address_d, input, 2*address_width bits, write addresses; slice k belongs to port k.
REQ-010 SHALL have port data_dval, input, 2*data_width bits, write data; slice k belongs to port k.
REQ-011 SHALL have port address_s, input, num_read*address_width bits, read addresses; slice j belongs to read port j.
REQ-012 SHALL have port data_sval, output, num_read*data_width bits, read data; slice j belongs to read port j.
REQ-013 SHALL have port clear_req, input, 1 bit, single-cycle request to zero the whole file.
REQ-014 SHALL have port ready, output, 1 bit; high when the file accepts writes.
REQ-015 SHALL have port write_conflict, output, 1 bit, registered collision flag.

Function
REQ-016 Reads SHALL be combinational from the array, so there is zero-cycle read latency.
REQ-017 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded and SHALL NOT be forwarded.
REQ-018 When ready=1 and write_enable[k]=1, register address_d[k] SHALL take data_dval[k] at the next rising edge.
REQ-019 When both ports write the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 In the REQ-019 case, write_conflict SHALL be 1 in the following cycle and 0 otherwise.
REQ-021 With bypass=1, a read of nonzero address A in a cycle where an enabled write targets A SHALL return that write's data (port 1 winning on collision).
REQ-022 With bypass=0, a read in the REQ-021 case SHALL return the old contents.
REQ-023 The FSM SHALL have two states, CLEAR and READY; ready=1 only in READY.
REQ-024 CLEAR SHALL zero one register per cycle, walking an index counter from 0 to reg_depth-1.
REQ-025 When the counter reaches reg_depth-1, CLEAR SHALL transition to READY, so CLEAR lasts exactly reg_depth cycles.
REQ-026 In CLEAR, all data_sval slices SHALL read 0 and write_enable SHALL be ignored.
REQ-027 In CLEAR, write_conflict SHALL be 0.
REQ-028 In READY, clear_req=1 SHALL enter CLEAR at the next edge with the counter at 0.
REQ-029 If clear_req and writes occur in the same cycle, the writes SHALL be discarded.
REQ-030 clear_req asserted during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-031 The counter SHALL be address_width bits wide and SHALL NOT wrap past reg_depth-1.

Reset
REQ-032 While reset=0 at a rising edge, the FSM SHALL enter CLEAR with counter=0, and ready and write_conflict SHALL be 0.
REQ-033 Register contents SHALL be zeroed by the CLEAR sweep, not by reset directly.
REQ-034 A reset during CLEAR or READY SHALL restart the sweep from index 0.
REQ-035 The first cycle with ready=1 SHALL be reg_depth cycles after reset deasserts.

Structure
REQ-036 A shared package reg_file_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default width and depth constants.
REQ-037 A single sub-module, reg_file_clear_seq, SHALL hold the FSM and the counter, outputting ready, a clear-write enable and a clear index.
REQ-038 The array, write ports, bypass and read muxes SHALL live in reg_file_mp.

Verification
REQ-039 Release reset, count cycles -> ready rises after exactly 32 cycles; all read ports return 0 for addresses 0..31 throughout.
REQ-040 Write port 0 addr 5 = 0xA5, then read s0=5 next cycle -> 0xA5; write addr 0 = 0xFF -> address 0 still reads 0.
REQ-041 bypass=1: write addr 7 = 0x77 while s1=7 in the same cycle -> 0x77 that cycle; with bypass=0 -> old value 0.
REQ-042 Both ports write addr 9 (p0=0x11, p1=0x22) -> addr 9 reads 0x22; write_conflict=1 for exactly one cycle.
REQ-043 Fill regs 1..31 with i, pulse clear_req with a simultaneous write to addr 3 -> ready low for 32 cycles; all regs 0; the addr-3 write is lost.
REQ-044 Assert reset at sweep index 10, then release -> sweep restarts at 0; ready rises 32 cycles after release; a clear_req pulse mid-sweep does not extend it.
